// File: rtl/snoop_loader_pkg.sv
// snoop_loader_pkg
//   Shared definitions for the host-side snoop loader: command opcodes,
//   the loader state encoding and default parameter values.
package snoop_loader_pkg;

    localparam logic [7:0] CMD_WMEM = 8'h01;   // write data memory
    localparam logic [7:0] CMD_WPRG = 8'h02;   // write program RAM
    localparam logic [7:0] CMD_RMEM = 8'h03;   // read data memory

    localparam logic [7:0]  DEFAULT_ACK_BYTE = 8'hA5;
    localparam int unsigned DEFAULT_TIMEOUT  = 65535;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_COUNT  = 3'd2,
        ST_WDATA  = 3'd3,
        ST_ACK    = 3'd4,
        ST_RISSUE = 3'd5,
        ST_RCAPT  = 3'd6,
        ST_RSEND  = 3'd7
    } loader_state_t;

    function automatic logic is_valid_cmd(input logic [7:0] b);
        return (b == CMD_WMEM) || (b == CMD_WPRG) || (b == CMD_RMEM);
    endfunction

endpackage

// File: rtl/snoop_loader.sv
// snoop_loader
//   Decodes CMD/ADDR/COUNT byte commands from the host link and drives the
//   CPU snoop bus: single-cycle write strobes into data memory or program
//   RAM, and data-memory reads returned on the outbound byte stream.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready   inbound command and data bytes
//   tx_data/tx_valid/tx_ready   outbound readback bytes and write acks
//   snoopa/snoopd               snoop address / write data (registered)
//   snoopm/snoopp               data-memory / program-RAM write strobes
//   snoopq                      data-memory readback, one cycle after snoopa
//   busy                        high whenever the loader is not idle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command byte; unknown opcodes are dropped
// ADDR   | waiting for the start address
// COUNT  | waiting for the byte count (0 = 256)
// WDATA  | each accepted byte produces one write strobe
// ACK    | presenting ACK_BYTE until taken
// RISSUE | snoopa holds the read address for the core
// RCAPT  | snoopq valid; latched into the tx register
// RSEND  | holding the readback byte until taken
module snoop_loader
    import snoop_loader_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE = DEFAULT_ACK_BYTE,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] snoopa,
    output logic [7:0] snoopd,
    output logic       snoopm,
    output logic       snoopp,
    input  logic [7:0] snoopq,
    output logic       busy
);

    // The timer is reloaded on every accepted byte and expires on the
    // TIMEOUT-th consecutive idle cycle, when it has counted down to zero.
    localparam logic        TMO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LOAD = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    loader_state_t state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    addr_q, addr_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [15:0]   tmo_q, tmo_d;
    logic [7:0]    snoopa_q, snoopa_d;
    logic [7:0]    snoopd_q, snoopd_d;
    logic          snoopm_q, snoopm_d;
    logic          snoopp_q, snoopp_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;

    logic rx_accept;
    logic tmo_counting;
    logic tmo_hit;

    assign rx_ready = (state_q == ST_IDLE)  || (state_q == ST_ADDR) ||
                      (state_q == ST_COUNT) || (state_q == ST_WDATA);
    assign rx_accept = rx_valid && rx_ready;

    assign tmo_counting = TMO_EN && ((state_q == ST_ADDR) || (state_q == ST_COUNT) ||
                                     (state_q == ST_WDATA));
    assign tmo_hit = tmo_counting && !rx_accept && (tmo_q == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 8'd0;
            addr_q     <= 8'd0;
            cnt_q      <= 9'd0;
            tmo_q      <= 16'd0;
            snoopa_q   <= 8'd0;
            snoopd_q   <= 8'd0;
            snoopm_q   <= 1'b0;
            snoopp_q   <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            snoopa_q   <= snoopa_d;
            snoopd_q   <= snoopd_d;
            snoopm_q   <= snoopm_d;
            snoopp_q   <= snoopp_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        snoopa_d   = snoopa_q;
        snoopd_d   = snoopd_q;
        snoopm_d   = 1'b0;
        snoopp_d   = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        if (rx_accept) begin
            tmo_d = TMO_LOAD;
        end else if (tmo_counting && (tmo_q != 16'd0)) begin
            tmo_d = tmo_q - 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_accept && is_valid_cmd(rx_data)) begin
                    cmd_d   = rx_data;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (rx_accept) begin
                    addr_d  = rx_data;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (rx_accept) begin
                    cnt_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    if (cmd_q == CMD_RMEM) begin
                        // Address goes out now so the core sees it during RISSUE.
                        snoopa_d = addr_q;
                        state_d  = ST_RISSUE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else if (rx_accept) begin
                    snoopa_d = addr_q;
                    snoopd_d = rx_data;
                    snoopm_d = (cmd_q == CMD_WMEM);
                    snoopp_d = (cmd_q == CMD_WPRG);
                    addr_d   = addr_q + 8'd1;
                    cnt_d    = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                // First ACK cycle coincides with the last strobe; the ack
                // byte appears one cycle later.
                if (!tx_valid_q) begin
                    tx_data_d  = ACK_BYTE;
                    tx_valid_d = 1'b1;
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_RISSUE: begin
                state_d = ST_RCAPT;
            end
            ST_RCAPT: begin
                tx_data_d  = snoopq;
                tx_valid_d = 1'b1;
                state_d    = ST_RSEND;
            end
            ST_RSEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + 8'd1;
                    cnt_d      = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        snoopa_d = addr_q + 8'd1;
                        state_d  = ST_RISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign snoopa   = snoopa_q;
    assign snoopd   = snoopd_q;
    assign snoopm   = snoopm_q;
    assign snoopp   = snoopp_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snoop_loader.sv
`timescale 1ns/1ps
module tb_snoop_loader;
    import snoop_loader_pkg::*;

    localparam int unsigned TMO = 16;
    localparam logic [7:0]  ACK = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] snoopa, snoopd, snoopq;
    logic       snoopm, snoopp, busy;

    always #5 clk = ~clk;

    snoop_loader #(.ACK_BYTE(ACK), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .snoopa(snoopa), .snoopd(snoopd), .snoopm(snoopm), .snoopp(snoopp),
        .snoopq(snoopq), .busy(busy)
    );

    // Core-side data memory: writes commit on the edge after the strobe
    // cycle, readback registered one cycle after snoopa.
    logic [7:0] core_dmem [256];
    always @(posedge clk) begin
        if (snoopm) core_dmem[snoopa] <= snoopd;
        snoopq <= core_dmem[snoopa];
    end

    // tx_ready driver: either forced or random each cycle.
    bit   tx_rand = 1'b0;
    logic txr_force = 1'b1;
    always @(posedge clk) begin
        #1 tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : txr_force;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model and scoreboard.
    typedef struct packed {
        logic       prg;
        logic [7:0] a;
        logic [7:0] d;
    } strobe_t;

    logic [7:0] ref_dmem [256];
    strobe_t    exp_strobe_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] wdata_q[$];

    bit      mon_en = 1'b0;
    bit      rec_en = 1'b0;
    int      strobe_cnt = 0;
    int      strobe_cyc[$];
    int      txv_rise_cyc = 0;
    logic    prev_stall = 1'b0;
    logic    prev_txv = 1'b0;
    logic [7:0] prev_tx = 8'd0;
    strobe_t mon_e;
    logic [7:0] mon_b;

    always @(negedge clk) begin
        if (mon_en) begin
            if (snoopm || snoopp) begin
                strobe_cnt++;
                if (rec_en) strobe_cyc.push_back(cyc);
                chk("strobe_exclusive", 32'(snoopm & snoopp), 32'd0);
                if (exp_strobe_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got addr %02h data %02h expected none", snoopa, snoopd);
                end else begin
                    mon_e = exp_strobe_q.pop_front();
                    chk("strobe_kind_prg", 32'(snoopp), 32'(mon_e.prg));
                    chk("strobe_addr", 32'(snoopa), 32'(mon_e.a));
                    chk("strobe_data", 32'(snoopd), 32'(mon_e.d));
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %02h expected none", tx_data);
                end else begin
                    mon_b = exp_tx_q.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(mon_b));
                end
            end
            if (prev_stall) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_data", 32'(tx_data), 32'(prev_tx));
            end
            if (tx_valid && !prev_txv) txv_rise_cyc = cyc;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_tx    = tx_data;
        prev_txv   = tx_valid;
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_accept_timeout: got rx_ready 0 expected 1 for byte %02h", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input bit en);
        int g;
        if (en) begin
            g = $urandom_range(0, 3);
            if (g != 0) begin
                rx_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    // Write n bytes (1..256) taken from wdata_q.
    task automatic do_write(input logic [7:0] cmd, input logic [7:0] addr, input int n, input bit gaps);
        logic [7:0] d;
        logic [7:0] a;
        send_byte(cmd);
        gap(gaps);
        send_byte(addr);
        gap(gaps);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            d = wdata_q.pop_front();
            exp_strobe_q.push_back('{prg: (cmd == CMD_WPRG), a: a, d: d});
            if (cmd == CMD_WMEM) ref_dmem[a] = d;
            if (i == n - 1) exp_tx_q.push_back(ACK);
            gap(gaps);
            send_byte(d);
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, input int n, input bit gaps);
        send_byte(CMD_RMEM);
        gap(gaps);
        send_byte(addr);
        gap(gaps);
        for (int i = 0; i < n; i++) exp_tx_q.push_back(ref_dmem[addr + 8'(i)]);
        send_byte(8'(n));
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy && !tx_valid && exp_tx_q.size() == 0 && exp_strobe_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: got busy %0d, %0d tx and %0d strobes pending expected idle",
                     busy, exp_tx_q.size(), exp_strobe_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        int op, n;
        logic [7:0] a;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_snoopa", 32'(snoopa), 32'd0);
        chk("rst_snoopd", 32'(snoopd), 32'd0);
        chk("rst_snoopm", 32'(snoopm), 32'd0);
        chk("rst_snoopp", 32'(snoopp), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a write
        send_byte(CMD_WMEM);
        send_byte(8'h80);
        send_byte(8'h04);
        send_byte(8'h11);
        chk("midwr_strobe_before_rst", 32'(snoopm), 32'd1);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midwr_snoopm_dropped", 32'(snoopm), 32'd0);
        chk("midwr_busy", 32'(busy), 32'd0);
        chk("midwr_snoopa", 32'(snoopa), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midwr_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;

        mon_en = 1'b1;

        // COUNT = 0: fill all 256 data-memory bytes
        s0 = strobe_cnt;
        for (int i = 0; i < 256; i++) wdata_q.push_back(8'($urandom));
        do_write(CMD_WMEM, 8'h00, 256, 1'b1);
        wait_idle();
        chk("count0_strobes", 32'(strobe_cnt - s0), 32'd256);

        // Program write, back-to-back bytes
        strobe_cyc.delete();
        rec_en = 1'b1;
        wdata_q.push_back(8'hAA);
        wdata_q.push_back(8'hBB);
        wdata_q.push_back(8'hCC);
        do_write(CMD_WPRG, 8'h10, 3, 1'b0);
        wait_idle();
        rec_en = 1'b0;
        if (strobe_cyc.size() == 3) begin
            chk("prg_b2b_1", 32'(strobe_cyc[1]), 32'(strobe_cyc[0] + 1));
            chk("prg_b2b_2", 32'(strobe_cyc[2]), 32'(strobe_cyc[1] + 1));
            chk("prg_ack_timing", 32'(txv_rise_cyc), 32'(strobe_cyc[2] + 1));
        end else begin
            chk("prg_strobe_count", 32'(strobe_cyc.size()), 32'd3);
        end

        // Address wrap, then read back across the wrap
        wdata_q.push_back(8'h11);
        wdata_q.push_back(8'h22);
        wdata_q.push_back(8'h33);
        do_write(CMD_WMEM, 8'hFE, 3, 1'b0);
        wait_idle();
        do_read(8'hFE, 3, 1'b0);
        wait_idle();

        // Read with backpressure
        wdata_q.push_back(8'h5A);
        wdata_q.push_back(8'hC3);
        do_write(CMD_WMEM, 8'h40, 2, 1'b0);
        wait_idle();
        txr_force = 1'b0;
        @(posedge clk);
        #2;
        do_read(8'h40, 2, 1'b0);
        for (int k = 0; k < 10 && !tx_valid; k++) @(negedge clk);
        chk("bp_tx_valid", 32'(tx_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_5a", 32'(tx_data), 32'h5A);
            chk("bp_rx_ready_low", 32'(rx_ready), 32'd0);
        end
        txr_force = 1'b1;
        for (int k = 0; k < 20 && busy; k++) begin
            @(negedge clk);
            if (busy) chk("bp_rx_ready_read", 32'(rx_ready), 32'd0);
        end
        wait_idle();

        // Timeout after CMD, ADDR
        send_byte(CMD_WMEM);
        send_byte(8'h20);
        rx_valid = 1'b0;
        repeat (TMO) @(negedge clk);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        chk("tmo_busy_after", 32'(busy), 32'd0);
        chk("tmo_no_ack", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
        send_byte(8'h7F);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("badcmd_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        wdata_q.push_back(8'h55);
        do_write(CMD_WMEM, 8'h20, 1, 1'b0);
        wait_idle();

        // Randomized traffic
        tx_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            n  = $urandom_range(1, 8);
            a  = 8'($urandom);
            case (op)
                0, 1: begin
                    for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom));
                    do_write((op == 0) ? CMD_WMEM : CMD_WPRG, a, n, 1'b1);
                end
                2: do_read(a, n, 1'b1);
                default: begin
                    send_byte(8'($urandom_range(4, 255)));
                    rx_valid = 1'b0;
                end
            endcase
            wait_idle();
        end
        tx_rand = 1'b0;

        chk("end_strobe_q_empty", 32'(exp_strobe_q.size()), 32'd0);
        chk("end_tx_q_empty", 32'(exp_tx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
